multi_edge_detector: RTL
========================

# multi_edge_detector

Parametrised multi-channel edge detector for the button/sensor inputs of the robot controller. Each channel synchronises an asynchronous input and debounces it. It then emits registered rise/fall pulses and keeps per-channel sticky event flags with clear. A single interrupt line feeds the game-control FSM. It extends the single-channel detector with channel width, synchronisation depth, glitch filtering and event latching.

## Interface
- WIDTH, 8: number of independent channels (≥1)
- SYNC_STAGES, 2: flip-flops in each input synchroniser chain (≥1)
- DEBOUNCE, 16: consecutive enabled cycles a synchronised input must differ from `level` before `level` changes (≥1; 1 = no filtering)
- CNT_W, $clog2(DEBOUNCE+1): debounce counter width (derived, not overridden)

- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  reset, synchronous, active-low
- enable  input  1  when 0, debounce/edge/pulse logic is frozen; synchronisers and `clear` keep working
- data_in  input  WIDTH  raw asynchronous channel inputs
- clear  input  WIDTH  per-channel flag clear, sampled on clk
- level  output  WIDTH  debounced, synchronised channel state
- pulse_rise  output  WIDTH  one-cycle pulse on a 0→1 change of `level[i]`
- pulse_fall  output  WIDTH  one-cycle pulse on a 1→0 change of `level[i]`
- pulse_both  output  WIDTH  `pulse_rise | pulse_fall`
- flag_rise  output  WIDTH  sticky: a rise occurred since the last clear
- flag_fall  output  WIDTH  sticky: a fall occurred since the last clear
- irq  output  1  OR-reduction of `flag_rise | flag_fall`

## Operation
- Reset, when `rst_n`=0 at a clk edge:
  - synchroniser chains, `level`, counters, pulses and flags all go to 0, so `irq`=0.
  - Reset overrides `enable` and `clear`.
  - Reset mid-debounce discards the partial count; no pulse is produced on the reset edge.
- Synchroniser: each edge shifts `data_in[i]` into an SYNC_STAGES-deep chain, regardless of `enable`. `sync[i]` is the last stage.
- Debounce, on each edge with `enable`=1, per channel:
  - `sync[i]`==`level[i]`: `cnt[i]`←0.
  - `sync[i]`!=`level[i]` and `cnt[i]`==DEBOUNCE-1: `level[i]`←`sync[i]`, `cnt[i]`←0, and the matching pulse register loads 1.
  - Otherwise: `cnt[i]`←`cnt[i]`+1.
  - Any input excursion shorter than DEBOUNCE enabled cycles (after synchronisation) is rejected with no level change and no pulse.
- Pulses:
  - Registered. The pulse register loads 0 on every edge without a level change, including every edge with `enable`=0.
  - `pulse_rise[i]` and `pulse_fall[i]` are never both 1.
  - Each pulse is high exactly in the first cycle `level[i]` shows its new value.
- `enable`=0: `cnt`, `level` and flags hold (except for clears); pulses are 0. Re-enabling resumes counting from the held `cnt`.
- Flags, per channel and edge: `flag_x[i]` ← (`flag_x[i]` & ~`clear[i]`) | `new_x[i]`, where `new_x` is the value being loaded into `pulse_x` at that edge.
  - An event and a clear at the same edge leave the flag 1; events are never lost.
  - `clear[i]` clears both flags of channel i.
- Channels are fully independent. Simultaneous events on several channels set all their flags.
- Inputs high at reset release are treated as a real rise: `level` goes 1 after the normal latency, with `pulse_rise` and `flag_rise`.

## Timing
- Latency: a `data_in[i]` change that is stable before edge 1 shows on `level[i]` and `pulse_x[i]` right after edge SYNC_STAGES+DEBOUNCE, assuming `enable` is continuously 1. Each disabled cycle adds one cycle.
- Pulse width: exactly 1 clk cycle.
- Minimum spacing between successive edges on one channel: DEBOUNCE cycles.
- `irq` is combinational from the flag registers, with no added latency. It rises in the same cycle as the pulse that set the flag.
- Clear: a flag drops right after the edge that samples `clear[i]`=1, provided no event loads on that edge.

## Test plan
All scenarios use WIDTH=4, SYNC_STAGES=2, DEBOUNCE=4, with `enable`=1 unless stated.
- Reset: hold `rst_n`=0 for 3 edges with `data_in`=4'hF → all outputs 0. Release → `level`=4'hF after edge 6, with `pulse_rise`=4'hF for one cycle and `flag_rise`=4'hF, `irq`=1.
- Debounce reject: `data_in[0]` 0→1 for 3 cycles, then back to 0 → `level[0]`, pulses and flags stay 0. Then hold 1 steady → `level[0]`=1 and `pulse_rise[0]`=1 after edge 6 from the change, one cycle only.
- Fall and both: drive `data_in[2]` 1→0 after it has settled at 1 → `pulse_fall[2]`=1 and `pulse_both[2]`=1 for one cycle; `pulse_rise`=0; `flag_fall[2]`=1.
- Enable freeze: drop `enable` for 5 cycles midway through the count → `level` holds and no pulse; after re-enable, the edge arrives 5 cycles later than the nominal 6-edge latency.
- Clear collision: assert `clear[1]` on the same edge a new rise registers on channel 1 → `flag_rise[1]` stays 1. Assert `clear[1]` on a later edge → `flag_rise[1]`=0, `flag_fall[1]`=0, and `irq`=0 if no other flags are set.
- Reset mid-count: assert `rst_n`=0 during the 3rd differing cycle of channel 3 → `level[3]`=0, `cnt` cleared, and no pulse at that edge or after release.

Source files
------------

// File: rtl/multi_edge_detector.sv
// Multi-channel input conditioner: per-channel synchroniser, debounce filter,
// registered rise/fall pulses, sticky event flags with clear, and one irq line.
module multi_edge_detector #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] clear,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pulse_rise,
  output logic [WIDTH-1:0] pulse_fall,
  output logic [WIDTH-1:0] pulse_both,
  output logic [WIDTH-1:0] flag_rise,
  output logic [WIDTH-1:0] flag_fall,
  output logic             irq
);

  localparam int             CNT_W   = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  // sync_q[0] samples data_in; the last stage is the synchronised value.
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_w;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] level_q,     level_d;
  logic [WIDTH-1:0] rise_q,      rise_d;
  logic [WIDTH-1:0] fall_q,      fall_d;
  logic [WIDTH-1:0] flag_rise_q, flag_rise_d;
  logic [WIDTH-1:0] flag_fall_q, flag_fall_d;

  assign sync_w = sync_q[SYNC_STAGES-1];

  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (enable) begin
        if (sync_w[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync_w[i];
          cnt_d[i]   = '0;
          rise_d[i]  = sync_w[i];
          fall_d[i]  = ~sync_w[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    // A new event wins over a simultaneous clear so no event is lost.
    flag_rise_d = (flag_rise_q & ~clear) | rise_d;
    flag_fall_d = (flag_fall_q & ~clear) | fall_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      level_q     <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      flag_rise_q <= '0;
      flag_fall_q <= '0;
    end else begin
      sync_q[0] <= data_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      level_q     <= level_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      flag_rise_q <= flag_rise_d;
      flag_fall_q <= flag_fall_d;
    end
  end

  assign level      = level_q;
  assign pulse_rise = rise_q;
  assign pulse_fall = fall_q;
  assign pulse_both = rise_q | fall_q;
  assign flag_rise  = flag_rise_q;
  assign flag_fall  = flag_fall_q;
  assign irq        = |(flag_rise_q | flag_fall_q);

endmodule
